// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD / 7-segment converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Segment patterns for digits 0-9, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_CODES [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Decimal digits of 2^width - 1, i.e. floor(width * log10(2)) + 1.
  function automatic int min_digits(input int width);
    longint scaled;
    scaled = longint'(width) * longint'(301029995);
    return int'(scaled / longint'(1000000000)) + 1;
  endfunction

endpackage

// File: rtl/bcd_seg7.sv
// One BCD digit to a 7-segment pattern; blank or an invalid digit gives all segments off.
module bcd_seg7
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    if (!blank && digit < 4'd10) begin
      seg = SEG_CODES[digit];
    end
  end

endmodule

// File: rtl/seq_bin2bcd_seg7.sv
// Iterative double-dabble binary-to-BCD converter with per-digit 7-segment encoding,
// optional leading-zero blanking and valid/ready handshakes on both sides.
module seq_bin2bcd_seg7
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  blank_lz,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 1 || DIGITS < min_digits(WIDTH)) begin : g_bad_params
    $error("seq_bin2bcd_seg7: DIGITS=%0d cannot hold 2^%0d-1", DIGITS, WIDTH);
  end

  state_t              state;
  logic [WIDTH-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [CW-1:0]       cnt;
  logic                blank_q;
  logic                result_shown;
  logic [DIGITS-1:0]   blank_mask;
  logic [7*DIGITS-1:0] seg_raw;
  logic                lead;

  // Add-3 correction applied to every digit before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt          <= '0;
      blank_q      <= 1'b0;
      result_shown <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_q        <= bin;
            blank_q      <= blank_lz;
            bcd_q        <= '0;
            cnt          <= CW'(WIDTH);
            result_shown <= 1'b0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt            <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state        <= DONE;
            result_shown <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    blank_mask = '0;
    lead       = blank_q;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead          = lead && (bcd_q[4*i +: 4] == 4'd0);
      blank_mask[i] = lead;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_seg7 u_seg (
      .digit (bcd_q[4*g +: 4]),
      .blank (blank_mask[g]),
      .seg   (seg_raw[7*g +: 7])
    );
  end

  // Segments stay dark until a conversion has completed since reset/acceptance.
  assign seg       = result_shown ? seg_raw : '0;
  assign bcd       = bcd_q;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule
